// File: rtl/rr_arbiter_buf.sv
// rr_arbiter_buf: N-way fixed-priority/round-robin arbiter with burst lock and a registered output stage
module rr_arbiter_buf #(
    parameter int N = 4,
    parameter int W = 32,
    localparam int CW = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_mode,
    input  logic [N-1:0]     io_in_valid,
    output logic [N-1:0]     io_in_ready,
    input  logic [N*W-1:0]   io_in_bits_data,
    input  logic [N-1:0]     io_in_bits_last,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [W-1:0]     io_out_bits_data,
    output logic             io_out_bits_last,
    output logic [CW-1:0]    io_out_chosen
);
    logic          lock;
    logic [CW-1:0] lidx;
    logic [CW-1:0] ptr;
    logic          gv;
    logic [CW-1:0] gidx;
    logic          space;
    logic          fire;

    assign space = !io_out_valid | io_out_ready;
    assign fire  = gv & space;

    // Pick the granted channel: locked burst owner, else scan from the priority start so the first valid hit wins
    always_comb begin
        int j;
        gv   = 1'b0;
        gidx = '0;
        j    = 0;
        if (lock) begin
            gv   = io_in_valid[lidx];
            gidx = lidx;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = io_mode ? ((int'(ptr) + k) % N) : k;
                if (io_in_valid[j]) begin
                    gv   = 1'b1;
                    gidx = CW'(j);
                end
            end
        end
    end

    // Ready is the one-hot grant, gated by a free stage and held low while reset is asserted
    always_comb begin
        io_in_ready = '0;
        if (fire && reset) io_in_ready[gidx] = 1'b1;
    end

    // Output register, burst lock and round-robin pointer; a fire replaces the beat, otherwise a drain empties it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_valid     <= 1'b0;
            io_out_bits_data <= '0;
            io_out_bits_last <= 1'b0;
            io_out_chosen    <= '0;
            lock             <= 1'b0;
            lidx             <= '0;
            ptr              <= '0;
        end else if (fire) begin
            io_out_valid     <= 1'b1;
            io_out_bits_data <= io_in_bits_data[int'(gidx)*W +: W];
            io_out_bits_last <= io_in_bits_last[gidx];
            io_out_chosen    <= gidx;
            lock             <= !io_in_bits_last[gidx];
            lidx             <= gidx;
            if (io_mode) ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_buf.sv
// tb_rr_arbiter_buf: directed and random checks of rr_arbiter_buf against a behavioural arbitration model
module tb_rr_arbiter_buf;
    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic           io_mode;
    logic [N-1:0]   io_in_valid;
    logic [N-1:0]   io_in_ready;
    logic [N*W-1:0] io_in_bits_data;
    logic [N-1:0]   io_in_bits_last;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_bits_data;
    logic           io_out_bits_last;
    logic [1:0]     io_out_chosen;

    int n_cmp = 0;
    int n_err = 0;

    // model state: the beat the consumer should see, plus arbitration memory
    logic         m_ov;
    logic [W-1:0] m_data;
    logic         m_last;
    int           m_ch;
    int           m_ptr;
    logic         m_lock;
    int           m_lidx;

    rr_arbiter_buf #(.N(N), .W(W)) dut (
        .clock(clock),
        .reset(reset),
        .io_mode(io_mode),
        .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready),
        .io_in_bits_data(io_in_bits_data),
        .io_in_bits_last(io_in_bits_last),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_out_bits_data(io_out_bits_data),
        .io_out_bits_last(io_out_bits_last),
        .io_out_chosen(io_out_chosen)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_ch = 0;
        m_ptr = 0; m_lock = 1'b0; m_lidx = 0;
    endtask

    // channel that wins under the current rules, or -1 when nobody is eligible
    function automatic int pick();
        int j;
        if (m_lock) return io_in_valid[m_lidx] ? m_lidx : -1;
        for (int k = 0; k < N; k++) begin
            j = io_mode ? (m_ptr + k) % N : k;
            if (io_in_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic rnd_data();
        io_in_bits_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // one clock: check ready before the edge, advance the model at the edge, check outputs after it
    task automatic cycle(input int exp_rdy, input int exp_ch);
        int g;
        logic sp;
        logic [N-1:0] er;
        #1;
        g  = pick();
        sp = !m_ov || io_out_ready;
        er = (g >= 0 && sp) ? N'(1 << g) : '0;
        chk("in_ready", io_in_ready, er);
        if (exp_rdy >= 0) chk("in_ready_dir", io_in_ready, exp_rdy);
        @(posedge clock);
        if (g >= 0 && sp) begin
            m_ov   = 1'b1;
            m_data = io_in_bits_data[g*W +: W];
            m_last = io_in_bits_last[g];
            m_ch   = g;
            m_lock = !io_in_bits_last[g];
            m_lidx = g;
            if (io_mode) m_ptr = (g + 1) % N;
        end else if (io_out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", io_out_valid, m_ov);
        chk("out_data", io_out_bits_data, m_data);
        chk("out_last", io_out_bits_last, m_last);
        chk("out_chosen", io_out_chosen, m_ch);
        if (exp_ch >= 0) chk("chosen_dir", io_out_chosen, exp_ch);
    endtask

    initial begin
        reset = 1'b0; io_mode = 1'b0; io_in_valid = 4'b1111; io_in_bits_last = 4'b1111;
        io_out_ready = 1'b1; rnd_data();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_in_ready", io_in_ready, 0);
        chk("rst_chosen", io_out_chosen, 0);
        chk("rst_data", io_out_bits_data, 0);
        reset = 1'b1;
        cycle(1, 0);
        // fixed priority: channel 1 always beats channel 3
        io_in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin rnd_data(); cycle(2, 1); end
        // round-robin rotation with every channel requesting
        io_mode = 1'b1; io_in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin rnd_data(); cycle(1 << (i % 4), i % 4); end
        // channel 2 burst holds the grant through a gap while channel 0 waits
        io_in_valid = 4'b0101; io_in_bits_last = 4'b1011;
        rnd_data(); cycle(4, 2);
        rnd_data(); cycle(4, 2);
        io_in_valid = 4'b0001;
        rnd_data(); cycle(0, 2);
        chk("gap_out_valid", io_out_valid, 0);
        rnd_data(); cycle(0, 2);
        io_in_valid = 4'b0101; io_in_bits_last = 4'b1111;
        rnd_data(); cycle(4, 2);
        rnd_data(); cycle(1, 0);
        // backpressure keeps the held beat stable, then refills with no bubble
        io_mode = 1'b0; io_in_valid = 4'b0001;
        rnd_data(); io_in_bits_data[31:0] = 32'hDEADBEEF;
        cycle(1, 0);
        chk("bp_load", io_out_bits_data, 32'hDEADBEEF);
        io_out_ready = 1'b0; io_in_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            rnd_data(); cycle(0, 0);
            chk("bp_hold", io_out_bits_data, 32'hDEADBEEF);
        end
        io_out_ready = 1'b1;
        rnd_data(); cycle(1, 0);
        chk("bp_refill_valid", io_out_valid, 1);
        // reset in the middle of a channel 3 burst
        io_in_valid = 4'b1000; io_in_bits_last = 4'b0000;
        rnd_data(); cycle(8, 3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_out_valid", io_out_valid, 0);
        chk("midrst_in_ready", io_in_ready, 0);
        @(posedge clock);
        #1;
        chk("midrst_hold", io_out_valid, 0);
        reset = 1'b1;
        io_in_valid = 4'b1001; io_in_bits_last = 4'b1111;
        rnd_data(); cycle(1, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            io_mode         = 1'($urandom_range(0, 1));
            io_in_valid     = 4'($urandom);
            io_in_bits_last = 4'($urandom) | 4'($urandom);
            io_out_ready    = $urandom_range(0, 3) != 0;
            rnd_data();
            cycle(-1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
